// File: rtl/decade_prescaler_ctrl_pkg.sv
// Shared types and constants for the decade prescaler controller and its digit cells.
package decade_prescaler_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      PEND = 2'd2
   } state_t;

   localparam logic [3:0] DIGIT_MAX  = 4'd9;
   localparam logic [3:0] HALF_POINT = 4'd5;

   // Width needed to hold a divide exponent in 0..n_stages.
   function automatic int unsigned sel_w(input int unsigned n_stages);
      return $clog2(n_stages + 1);
   endfunction

endpackage

// File: rtl/decade_prescaler_ctrl_digit.sv
// One decade (0-9) digit with synchronous clear, carry-in enable and carry-out.
module decade_digit
   import decade_prescaler_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       clr,
   input  logic       cin,
   output logic [3:0] q,
   output logic       cout
);

   always_ff @(posedge clk) begin
      if (reset || clr) begin
         q <= '0;
      end else if (cin) begin
         q <= (q == DIGIT_MAX) ? '0 : q + 4'd1;
      end
   end

   assign cout = (q == DIGIT_MAX) & cin;

endmodule

// File: rtl/decade_prescaler_ctrl.sv
// Divide-by-10^sel prescaler: cascaded decade digits, tick strobe, square out_clk, sel reconfig at wrap.
// Define DECADE_PRESCALER_BCD_OUT_EN to expose the live digit values on port bcd.
module decade_prescaler_ctrl
   import decade_prescaler_ctrl_pkg::*;
#(
   parameter int unsigned N_STAGES = 3,
   parameter int unsigned DEF_SEL  = 3,
   localparam int unsigned SEL_W   = sel_w(N_STAGES)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [SEL_W-1:0] cfg_sel,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   output logic [SEL_W-1:0] cur_sel,
   output logic             tick,
   output logic             out_clk,
   output logic             busy
`ifdef DECADE_PRESCALER_BCD_OUT_EN
   ,
   output logic [4*N_STAGES-1:0] bcd
`endif
);

   state_t              state, state_nx;
   logic [SEL_W-1:0]    cur_sel_nx;
   logic [SEL_W-1:0]    pend_sel, pend_sel_nx;
   logic [SEL_W-1:0]    sel_clamped;
   logic                tick_nx;
   logic                hi_digit;
   logic                wrap;
   logic                load_clr;

   logic [3:0]          digit [N_STAGES];
   logic [N_STAGES-1:0] cin;
   logic [N_STAGES-1:0] carry;
   logic [N_STAGES-1:0] clr;

   // Carry-in is derived from the digit registers directly rather than chained
   // through the cells' carry-outs, so no combinational path runs cell-to-cell.
   for (genvar k = 0; k < N_STAGES; k++) begin : g_digit
      logic all_nine;

      always_comb begin
         all_nine = 1'b1;
         for (int unsigned j = 0; j < N_STAGES; j++) begin
            if ((j < k) && (digit[j] != DIGIT_MAX)) begin
               all_nine = 1'b0;
            end
         end
      end

      assign cin[k] = en & all_nine & (SEL_W'(k) < cur_sel);
      assign clr[k] = load_clr | (SEL_W'(k) >= cur_sel);

      decade_digit u_digit (
         .clk   (clk),
         .reset (reset),
         .clr   (clr[k]),
         .cin   (cin[k]),
         .q     (digit[k]),
         .cout  (carry[k])
      );

`ifdef DECADE_PRESCALER_BCD_OUT_EN
      assign bcd[4*k +: 4] = digit[k];
`endif
   end

   assign sel_clamped = (cfg_sel > SEL_W'(N_STAGES)) ? SEL_W'(N_STAGES) : cfg_sel;

   // Wrap is the carry-out of the top active digit; with sel 0 every enabled cycle wraps.
   always_comb begin
      wrap     = 1'b0;
      hi_digit = 1'b0;
      if (cur_sel == '0) begin
         wrap = en;
      end
      for (int unsigned k = 0; k < N_STAGES; k++) begin
         if (SEL_W'(k + 1) == cur_sel) begin
            wrap     = carry[k];
            hi_digit = (digit[k] >= HALF_POINT);
         end
      end
   end

   always_comb begin
      state_nx    = state;
      cur_sel_nx  = cur_sel;
      pend_sel_nx = pend_sel;
      load_clr    = 1'b0;
      tick_nx     = wrap;
      unique case (state)
         IDLE: begin
            if (cfg_valid) begin
               cur_sel_nx = sel_clamped;
               load_clr   = 1'b1;
               tick_nx    = 1'b0;
            end
            if (en) begin
               state_nx = RUN;
            end
         end
         RUN: begin
            // An accept coinciding with a wrap is held until the following wrap.
            if (cfg_valid) begin
               pend_sel_nx = sel_clamped;
               state_nx    = PEND;
            end else if (!en) begin
               state_nx = IDLE;
            end
         end
         PEND: begin
            if (wrap) begin
               cur_sel_nx = pend_sel;
               load_clr   = 1'b1;
               state_nx   = RUN;
            end
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         cur_sel  <= SEL_W'(DEF_SEL);
         pend_sel <= '0;
         tick     <= 1'b0;
         out_clk  <= 1'b0;
      end else begin
         state    <= state_nx;
         cur_sel  <= cur_sel_nx;
         pend_sel <= pend_sel_nx;
         tick     <= tick_nx;
         out_clk  <= hi_digit;
      end
   end

   assign cfg_ready = (state != PEND);
   assign busy      = (state == PEND);

endmodule

// File: tb/tb_decade_prescaler_ctrl.sv
// Directed bench for decade_prescaler_ctrl; inputs driven and outputs sampled on the falling edge.
module tb_decade_prescaler_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       en;
   logic [1:0] cfg_sel;
   logic       cfg_valid;
   logic       cfg_ready;
   logic [1:0] cur_sel;
   logic       tick;
   logic       out_clk;
   logic       busy;

   logic       en2;
   logic [1:0] cfg_sel2;
   logic       cfg_valid2;
   logic       cfg_ready2;
   logic [1:0] cur_sel2;
   logic       tick2;
   logic       out_clk2;
   logic       busy2;

`ifdef DECADE_PRESCALER_BCD_OUT_EN
   logic [11:0] bcd;
   logic [7:0]  bcd2;
`endif

   int n_cmp = 0;
   int n_err = 0;
   int ticks, first, last, hi;
   logic [2:0] req7;

   always #5 clk = ~clk;

   decade_prescaler_ctrl #(.N_STAGES(3), .DEF_SEL(3)) u_dut (
      .clk       (clk),
      .reset     (reset),
      .en        (en),
      .cfg_sel   (cfg_sel),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .cur_sel   (cur_sel),
      .tick      (tick),
      .out_clk   (out_clk),
      .busy      (busy)
`ifdef DECADE_PRESCALER_BCD_OUT_EN
      ,
      .bcd       (bcd)
`endif
   );

   // Two-digit instance: requesting 3 exceeds N_STAGES and must clamp to 2.
   decade_prescaler_ctrl #(.N_STAGES(2), .DEF_SEL(1)) u_dut2 (
      .clk       (clk),
      .reset     (reset),
      .en        (en2),
      .cfg_sel   (cfg_sel2),
      .cfg_valid (cfg_valid2),
      .cfg_ready (cfg_ready2),
      .cur_sel   (cur_sel2),
      .tick      (tick2),
      .out_clk   (out_clk2),
      .busy      (busy2)
`ifdef DECADE_PRESCALER_BCD_OUT_EN
      ,
      .bcd       (bcd2)
`endif
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   initial begin
      reset = 1'b1; en = 1'b0; cfg_sel = '0; cfg_valid = 1'b0;
      en2 = 1'b0; cfg_sel2 = '0; cfg_valid2 = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_cur_sel", cur_sel, 3);
      check("rst_tick", tick, 0);
      check("rst_out_clk", out_clk, 0);
      check("rst_busy", busy, 0);
      check("rst_ready", cfg_ready, 1);
      check("rst_cur_sel2", cur_sel2, 1);

      // Divide by 1000 from reset.
      reset = 1'b0; en = 1'b1;
      ticks = 0; first = 0; last = 0; hi = 0;
      for (int i = 1; i <= 2000; i++) begin
         @(negedge clk);
         if (tick) begin
            ticks++;
            if (first == 0) first = i;
            last = i;
         end
         if (i > 1000 && out_clk) hi++;
      end
      check("div1000_first", first, 1000);
      check("div1000_ticks", ticks, 2);
      check("div1000_last", last, 2000);
      check("div1000_high", hi, 500);

      // Leave digits mid-count, then reconfigure to sel 1 from IDLE.
      repeat (3) @(negedge clk);
      en = 1'b0;
      repeat (2) @(negedge clk);
      cfg_sel = 2'd1; cfg_valid = 1'b1;
      @(negedge clk);
      cfg_valid = 1'b0;
      check("idle_cfg_sel", cur_sel, 1);
      check("idle_cfg_busy", busy, 0);
      en = 1'b1;
      ticks = 0; first = 0; last = 0; hi = 0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (tick) begin
            ticks++;
            if (first == 0) first = i;
            last = i;
         end
         if (i > 10 && out_clk) hi++;
      end
      check("div10_first", first, 10);
      check("div10_ticks", ticks, 2);
      check("div10_high", hi, 5);

      // sel 2, request sel 0 at count 37; applies at the wrap of count 99.
      en = 1'b0;
      repeat (2) @(negedge clk);
      cfg_sel = 2'd2; cfg_valid = 1'b1;
      @(negedge clk);
      cfg_valid = 1'b0;
      en = 1'b1;
      repeat (37) @(negedge clk);
      cfg_sel = 2'd0; cfg_valid = 1'b1;
      @(negedge clk);
      cfg_valid = 1'b0;
      check("pend_busy", busy, 1);
      check("pend_ready", cfg_ready, 0);
      check("pend_cur_sel", cur_sel, 2);
      repeat (61) @(negedge clk);
      check("pend99_busy", busy, 1);
      check("pend99_tick", tick, 0);
      @(negedge clk);
      check("apply_tick", tick, 1);
      check("apply_cur_sel", cur_sel, 0);
      check("apply_busy", busy, 0);
      check("apply_out_clk", out_clk, 1);
      @(negedge clk);
      check("sel0_tick", tick, 1);
      check("sel0_out_clk", out_clk, 0);

      // With sel 0 every cycle wraps: the accept edge must not apply the new value.
      cfg_sel = 2'd2; cfg_valid = 1'b1;
      @(negedge clk);
      cfg_valid = 1'b0;
      check("defer_cur_sel", cur_sel, 0);
      check("defer_busy", busy, 1);
      @(negedge clk);
      check("defer_apply_sel", cur_sel, 2);
      check("defer_apply_busy", busy, 0);

      // Hold en low for 20 cycles: the 100-cycle period stretches to 120.
      ticks = 0; last = 0;
      for (int i = 1; i <= 120; i++) begin
         en = !(i > 30 && i <= 50);
         @(negedge clk);
         if (tick) begin
            ticks++;
            last = i;
         end
      end
      en = 1'b1;
      check("hold_ticks", ticks, 1);
      check("hold_last", last, 120);

      // Requested 7 on the 2-bit port arrives as 3; 3 on the two-digit instance clamps to 2.
      en = 1'b0;
      repeat (2) @(negedge clk);
      req7 = 3'd7;
      cfg_sel = req7[1:0]; cfg_valid = 1'b1;
      cfg_sel2 = 2'd3; cfg_valid2 = 1'b1;
      @(negedge clk);
      cfg_valid = 1'b0; cfg_valid2 = 1'b0;
      check("clamp_cur_sel", cur_sel, 3);
      check("clamp_cur_sel2", cur_sel2, 2);

      // Reset while a configuration is pending.
      en = 1'b1;
      repeat (600) @(negedge clk);
      check("pre_rst_out_clk", out_clk, 1);
      cfg_sel = 2'd1; cfg_valid = 1'b1;
      @(negedge clk);
      cfg_valid = 1'b0;
      check("pre_rst_busy", busy, 1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("prst_cur_sel", cur_sel, 3);
      check("prst_busy", busy, 0);
      check("prst_ready", cfg_ready, 1);
      check("prst_tick", tick, 0);
      check("prst_out_clk", out_clk, 0);
      ticks = 0; first = 0;
      for (int i = 1; i <= 1000; i++) begin
         @(negedge clk);
         if (tick) begin
            ticks++;
            if (first == 0) first = i;
         end
      end
      check("prst_ticks", ticks, 1);
      check("prst_first", first, 1000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
